// File: rtl/seg_s2p_receiver_if.sv
// Four-wire shift link (sclk/sdin/sen/sclrn) plus the received-word outputs.
// master drives the link and consumes words; slave is the receiver.
interface seg_s2p_receiver_if #(
    parameter int DATA_BITS = 64
);
    logic                 sclk;
    logic                 sdin;
    logic                 sen;
    logic                 sclrn;
    logic [DATA_BITS-1:0] PData;
    logic                 valid;
    logic                 busy;
    logic                 frame_err;

    modport master (
        output sclk, sdin, sen, sclrn,
        input  PData, valid, busy, frame_err
    );

    modport slave (
        input  sclk, sdin, sen, sclrn,
        output PData, valid, busy, frame_err
    );
endinterface

// File: rtl/seg_s2p_receiver.sv
// Serial-to-parallel receiver for the 4-wire shift link; rebuilds a DATA_BITS
// word from the asynchronous serial stream and strobes valid for one cycle.
module seg_s2p_receiver #(
    parameter int DATA_BITS       = 64,
    parameter int DATA_COUNT_BITS = 6,
    parameter bit DIR             = 1'b1
) (
    input logic               clk,
    input logic               rst,
    seg_s2p_receiver_if.slave link
);
    // One extra counter bit so a full frame (cnt == DATA_BITS) is representable.
    localparam int            CW   = DATA_COUNT_BITS + 1;
    localparam logic [CW-1:0] FULL = CW'(DATA_BITS);

    typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

    state_t               state_q, state_d;
    logic [2:0]           sclk_sync_q, sclk_sync_d;
    logic [2:0]           sen_sync_q, sen_sync_d;
    logic [1:0]           sdin_sync_q, sdin_sync_d;
    logic [1:0]           sclrn_sync_q, sclrn_sync_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] pdata_q, pdata_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 frame_err_q, frame_err_d;
    logic                 sclk_r, sen_r, sdin_s, sclrn_s;
    logic [DATA_BITS-1:0] shifted;

    assign sclk_r  = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sen_r   = sen_sync_q[1] & ~sen_sync_q[2];
    assign sdin_s  = sdin_sync_q[1];
    assign sclrn_s = sclrn_sync_q[1];

    always_comb begin
        if (DIR) shifted = {shreg_q[DATA_BITS-2:0], sdin_s};
        else     shifted = {sdin_s, shreg_q[DATA_BITS-1:1]};
    end

    always_comb begin
        sclk_sync_d  = {sclk_sync_q[1:0], link.sclk};
        sen_sync_d   = {sen_sync_q[1:0], link.sen};
        sdin_sync_d  = {sdin_sync_q[0], link.sdin};
        sclrn_sync_d = {sclrn_sync_q[0], link.sclrn};
        state_d      = state_q;
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        ovf_d        = ovf_q;
        pdata_d      = pdata_q;
        valid_d      = 1'b0;
        frame_err_d  = 1'b0;

        // Link clear wins over everything on the link and silently drops the frame.
        if (!sclrn_s) begin
            state_d = IDLE;
            shreg_d = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sclk_r) begin
                        shreg_d = shifted;
                        cnt_d   = CW'(1);
                        state_d = sen_r ? DONE : RECV;
                    end else if (sen_r) begin
                        frame_err_d = 1'b1;
                    end
                end
                RECV: begin
                    if (sclk_r) begin
                        shreg_d = shifted;
                        if (cnt_q == FULL) ovf_d = 1'b1;
                        else               cnt_d = cnt_q + CW'(1);
                    end
                    if (sen_r) state_d = DONE;
                end
                DONE: begin
                    if (cnt_q == FULL && !ovf_q) begin
                        pdata_d = shreg_q;
                        valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    shreg_d = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d == RECV);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            sclk_sync_q  <= '0;
            sen_sync_q   <= '0;
            sdin_sync_q  <= '0;
            sclrn_sync_q <= '1;
            shreg_q      <= '0;
            pdata_q      <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sclk_sync_q  <= sclk_sync_d;
            sen_sync_q   <= sen_sync_d;
            sdin_sync_q  <= sdin_sync_d;
            sclrn_sync_q <= sclrn_sync_d;
            shreg_q      <= shreg_d;
            pdata_q      <= pdata_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign link.PData     = pdata_q;
    assign link.valid     = valid_q;
    assign link.busy      = busy_q;
    assign link.frame_err = frame_err_q;
endmodule

// File: tb/tb_seg_s2p_receiver.sv
// Drives an MSB-first and an LSB-first receiver with the same words and
// scoreboards every valid/frame_err pulse against hand-computed results.
module tb_seg_s2p_receiver;
    typedef struct {
        bit          isErr;
        logic [63:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sclk = 1'b0;
    logic sen = 1'b0;
    logic sclrn = 1'b1;
    logic sdinMsb = 1'b0;
    logic sdinLsb = 1'b0;

    exp_t        qMsb[$];
    exp_t        qLsb[$];
    exp_t        eMsb, eLsb;
    logic [63:0] expPrev = 64'd0;
    int          compared = 0;
    int          mismatched = 0;

    seg_s2p_receiver_if #(.DATA_BITS(64)) lnkMsb ();
    seg_s2p_receiver_if #(.DATA_BITS(64)) lnkLsb ();

    assign lnkMsb.sclk  = sclk;
    assign lnkMsb.sen   = sen;
    assign lnkMsb.sclrn = sclrn;
    assign lnkMsb.sdin  = sdinMsb;
    assign lnkLsb.sclk  = sclk;
    assign lnkLsb.sen   = sen;
    assign lnkLsb.sclrn = sclrn;
    assign lnkLsb.sdin  = sdinLsb;

    seg_s2p_receiver #(.DATA_BITS(64), .DATA_COUNT_BITS(6), .DIR(1'b1)) dutMsb (
        .clk  (clk),
        .rst  (rst),
        .link (lnkMsb.slave)
    );

    seg_s2p_receiver #(.DATA_BITS(64), .DATA_COUNT_BITS(6), .DIR(1'b0)) dutLsb (
        .clk  (clk),
        .rst  (rst),
        .link (lnkLsb.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    // Scoreboard monitors: every output pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (lnkMsb.valid === 1'b1 || lnkMsb.frame_err === 1'b1) begin
            checkOutput("msb_exclusive", 64'(lnkMsb.valid & lnkMsb.frame_err), 64'd0);
            if (qMsb.size() == 0) begin
                checkOutput("msb_unexpected_pulse", 64'({lnkMsb.valid, lnkMsb.frame_err}), 64'd0);
            end else begin
                eMsb = qMsb.pop_front();
                checkOutput("msb_kind_err", 64'(lnkMsb.frame_err), 64'(eMsb.isErr));
                checkOutput("msb_pdata", lnkMsb.PData, eMsb.data);
            end
        end
    end

    always @(negedge clk) begin
        if (lnkLsb.valid === 1'b1 || lnkLsb.frame_err === 1'b1) begin
            checkOutput("lsb_exclusive", 64'(lnkLsb.valid & lnkLsb.frame_err), 64'd0);
            if (qLsb.size() == 0) begin
                checkOutput("lsb_unexpected_pulse", 64'({lnkLsb.valid, lnkLsb.frame_err}), 64'd0);
            end else begin
                eLsb = qLsb.pop_front();
                checkOutput("lsb_kind_err", 64'(lnkLsb.frame_err), 64'(eLsb.isErr));
                checkOutput("lsb_pdata", lnkLsb.PData, eLsb.data);
            end
        end
    end

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_msb_pdata"}, lnkMsb.PData, 64'd0);
        checkOutput({tag, "_msb_flags"}, 64'({lnkMsb.valid, lnkMsb.busy, lnkMsb.frame_err}), 64'd0);
        checkOutput({tag, "_lsb_pdata"}, lnkLsb.PData, 64'd0);
        checkOutput({tag, "_lsb_flags"}, 64'({lnkLsb.valid, lnkLsb.busy, lnkLsb.frame_err}), 64'd0);
    endtask

    // Each bit: sdin set with sclk low, 4 clk low, 4 clk high.
    task automatic shiftBits(input logic [63:0] word, input int n, input bit simul);
        for (int i = 0; i < n; i++) begin
            sclk    = 1'b0;
            sdinMsb = word[63 - (i % 64)];
            sdinLsb = word[i % 64];
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            if (simul && i == n - 1) sen = 1'b1;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((qMsb.size() != 0 || qLsb.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checkOutput("drain", 64'(qMsb.size() + qLsb.size()), 64'd0);
    endtask

    task automatic applyStimulus(input logic [63:0] word, input int n, input bit simul);
        exp_t e;
        if (n == 64) begin
            e.isErr = 1'b0;
            e.data  = word;
            expPrev = word;
        end else begin
            e.isErr = 1'b1;
            e.data  = expPrev;
        end
        qMsb.push_back(e);
        qLsb.push_back(e);
        @(negedge clk);
        shiftBits(word, n, simul);
        if (!(simul && n > 0)) begin
            sen = 1'b1;
            repeat (4) @(negedge clk);
        end
        sen = 1'b0;
        waitDrain();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        checkIdle("reset");
        rst = 1'b1;
        repeat (3) @(negedge clk);

        applyStimulus(64'h0123_4567_89AB_CDEF, 64, 1'b0);
        applyStimulus(64'hDEAD_BEEF_CAFE_F00D, 63, 1'b0);
        applyStimulus(64'hDEAD_BEEF_CAFE_F00D, 65, 1'b0);
        applyStimulus(64'h0, 0, 1'b0);

        // Partial frame aborted by link clear, then a clean frame.
        @(negedge clk);
        shiftBits(64'h1234_5678_9ABC_DEF0, 20, 1'b0);
        checkOutput("busy_mid_frame", 64'({lnkMsb.busy, lnkLsb.busy}), 64'd3);
        sclrn = 1'b0;
        repeat (4) @(negedge clk);
        sclrn = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("busy_after_sclrn", 64'({lnkMsb.busy, lnkLsb.busy}), 64'd0);
        applyStimulus(64'hFFFF_0000_A5A5_5A5A, 64, 1'b0);

        applyStimulus(64'h5555_AAAA_3C3C_C3C3, 64, 1'b1);

        // Reset in the middle of a frame clears outputs immediately.
        @(negedge clk);
        shiftBits(64'h0F0F_F0F0_1111_2222, 30, 1'b0);
        checkOutput("busy_before_rst", 64'({lnkMsb.busy, lnkLsb.busy}), 64'd3);
        rst = 1'b0;
        #1;
        checkIdle("mid_reset");
        expPrev = 64'd0;
        sclk    = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        applyStimulus(64'h0000_0000_0000_0001, 64, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
